// File: rtl/digital_clock_ctrl.sv
// digital_clock_ctrl: BCD time-of-day clock with run/pause/set FSM, fast mode and 12/24 h display.
// Optional alarm enabled by DIGITAL_CLOCK_ALARM_EN. Rev 1.0
`default_nettype none
module digital_clock_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FAST_DIV = 1000,
  parameter int H12      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_run,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_fast,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic [2:0] state_o,
  output logic       blink,
  output logic       tick,
  output logic       alarm_hit
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM_NORM  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] TERM_FAST  = PW'(CLK_HZ / FAST_DIV - 1);
  localparam logic [PW-1:0] TERM_BLINK = PW'(CLK_HZ / 4 - 1);
  localparam logic [7:0]    HOUR_RST   = (H12 != 0) ? 8'h12 : 8'h00;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_PAUSE  = 3'd1,
    ST_SET_H  = 3'd2,
    ST_SET_M  = 3'd3,
    ST_SET_S  = 3'd4,
    ST_SET_AH = 3'd5,
    ST_SET_AM = 3'd6
  } state_t;

  state_t        state;
  logic          fast;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] bcnt;
  logic [7:0]    t_hour, t_min, t_sec;
  logic [7:0]    disp_h, disp_m;
  logic [8:0]    fmt;
  logic          do_run, do_mode, do_inc, do_fast;
  logic          in_set, tick_now;
  logic [PW-1:0] term;

  // BCD increment with wrap to 00 after max
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] max);
    if (v == max)         return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {pm, display hour}; 12 h mode maps 0 -> 12 and 13..23 -> 1..11
  function automatic logic [8:0] fmt_hour(input logic [7:0] h);
    logic [4:0] b;
    logic [4:0] d;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (b == 5'd0)       d = 5'd12;
    else if (b > 5'd12)  d = b - 5'd12;
    else                 d = b;
    if (H12 == 0) return {1'b0, h};
    return {(b >= 5'd12), (d >= 5'd10) ? {4'd1, 4'(d - 5'd10)} : {4'd0, d[3:0]}};
  endfunction

  assign do_run   = key_run;
  assign do_mode  = !key_run && key_mode;
  assign do_inc   = !key_run && !key_mode && key_inc;
  assign do_fast  = !key_run && !key_mode && !key_inc && key_fast;
  assign in_set   = (state == ST_SET_H) || (state == ST_SET_M) || (state == ST_SET_S) ||
                    (state == ST_SET_AH) || (state == ST_SET_AM);
  assign term     = fast ? TERM_FAST : TERM_NORM;
  // A run/fast key clears the prescaler, so it also suppresses a coincident terminal count
  assign tick_now = (state == ST_RUN) && !do_run && !do_fast && (pcnt == term);
  assign state_o  = state;

`ifdef DIGITAL_CLOCK_ALARM_EN
  logic [7:0] al_hour, al_min;
  logic [5:0] al_cnt;
  logic       al_hit;
  logic       any_key;

  assign any_key   = key_run | key_mode | key_inc | key_fast;
  assign alarm_hit = al_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_hit <= 1'b0;
      al_cnt <= 6'd0;
    end else if (any_key) begin
      al_hit <= 1'b0;
      al_cnt <= 6'd0;
    end else if (tick && state == ST_RUN && t_hour == al_hour && t_min == al_min &&
                 t_sec == 8'h00) begin
      al_hit <= 1'b1;
      al_cnt <= 6'd0;
    end else if (al_hit && tick) begin
      if (al_cnt == 6'd59) al_hit <= 1'b0;
      al_cnt <= al_cnt + 6'd1;
    end
  end
`else
  assign alarm_hit = 1'b0;
`endif

  always_comb begin
    disp_h = t_hour;
    disp_m = t_min;
`ifdef DIGITAL_CLOCK_ALARM_EN
    if (state == ST_SET_AH || state == ST_SET_AM) begin
      disp_h = al_hour;
      disp_m = al_min;
    end
`endif
    fmt = fmt_hour(disp_h);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      fast     <= 1'b0;
      pcnt     <= '0;
      bcnt     <= '0;
      t_hour   <= 8'h00;
      t_min    <= 8'h00;
      t_sec    <= 8'h00;
      tick     <= 1'b0;
      blink    <= 1'b0;
      hour_bcd <= HOUR_RST;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      pm       <= 1'b0;
`ifdef DIGITAL_CLOCK_ALARM_EN
      al_hour  <= 8'h00;
      al_min   <= 8'h00;
`endif
    end else begin
      tick <= tick_now;
      if (state != ST_RUN || do_run || do_fast || tick_now) pcnt <= '0;
      else                                                  pcnt <= pcnt + PW'(1);

      if (do_fast) fast <= !fast;

      if (do_run) begin
        state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
      end else if (do_mode) begin
        case (state)
          ST_PAUSE:  state <= ST_SET_H;
          ST_SET_H:  state <= ST_SET_M;
          ST_SET_M:  state <= ST_SET_S;
`ifdef DIGITAL_CLOCK_ALARM_EN
          ST_SET_S:  state <= ST_SET_AH;
          ST_SET_AH: state <= ST_SET_AM;
          ST_SET_AM: state <= ST_PAUSE;
`else
          ST_SET_S:  state <= ST_PAUSE;
`endif
          default:   state <= state;
        endcase
      end

      // tick_now and do_inc are exclusive: one needs RUN, the other a SET state
      if (tick_now) begin
        t_sec <= inc_bcd(t_sec, 8'h59);
        if (t_sec == 8'h59) begin
          t_min <= inc_bcd(t_min, 8'h59);
          if (t_min == 8'h59) t_hour <= inc_bcd(t_hour, 8'h23);
        end
      end else if (do_inc) begin
        case (state)
          ST_SET_H:  t_hour  <= inc_bcd(t_hour, 8'h23);
          ST_SET_M:  t_min   <= inc_bcd(t_min, 8'h59);
          ST_SET_S:  t_sec   <= inc_bcd(t_sec, 8'h59);
`ifdef DIGITAL_CLOCK_ALARM_EN
          ST_SET_AH: al_hour <= inc_bcd(al_hour, 8'h23);
          ST_SET_AM: al_min  <= inc_bcd(al_min, 8'h59);
`endif
          default:   ;
        endcase
      end

      if (!in_set) begin
        bcnt  <= '0;
        blink <= 1'b0;
      end else if (bcnt == TERM_BLINK) begin
        bcnt  <= '0;
        blink <= !blink;
      end else begin
        bcnt  <= bcnt + PW'(1);
      end

      hour_bcd <= fmt[7:0];
      pm       <= fmt[8];
      min_bcd  <= disp_m;
      sec_bcd  <= t_sec;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_digital_clock_ctrl.sv
// tb_digital_clock_ctrl: seconds-of-day reference model plus directed key sequences;
// a 24 h and a 12 h instance share the same stimulus.
`default_nettype none
module tb_digital_clock_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic key_run = 1'b0, key_mode = 1'b0, key_inc = 1'b0, key_fast = 1'b0;
  logic [7:0] d0_hour, d0_min, d0_sec, d1_hour, d1_min, d1_sec;
  logic [2:0] d0_state, d1_state;
  logic d0_pm, d0_blink, d0_tick, d0_hit, d1_pm, d1_blink, d1_tick, d1_hit;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  digital_clock_ctrl #(.CLK_HZ(100), .FAST_DIV(10), .H12(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_run(key_run), .key_mode(key_mode), .key_inc(key_inc),
    .key_fast(key_fast), .hour_bcd(d0_hour), .min_bcd(d0_min), .sec_bcd(d0_sec), .pm(d0_pm),
    .state_o(d0_state), .blink(d0_blink), .tick(d0_tick), .alarm_hit(d0_hit));

  digital_clock_ctrl #(.CLK_HZ(100), .FAST_DIV(10), .H12(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_run(key_run), .key_mode(key_mode), .key_inc(key_inc),
    .key_fast(key_fast), .hour_bcd(d1_hour), .min_bcd(d1_min), .sec_bcd(d1_sec), .pm(d1_pm),
    .state_o(d1_state), .blink(d1_blink), .tick(d1_tick), .alarm_hit(d1_hit));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Reference model: time as seconds of day, display lags by one cycle
  int m_secs, m_alh, m_alm, st, since, set_cyc, hit_ticks, w, e_h, e_m, e_s, hh, mm, ss;
  bit fast, e_tick, e_blink, e_hit, old_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_secs = 0; m_alh = 0; m_alm = 0; st = 0; since = 0; set_cyc = 0; hit_ticks = 0;
      fast = 0; e_tick = 0; e_blink = 0; e_hit = 0; e_h = 0; e_m = 0; e_s = 0;
    end else begin
      old_tick = e_tick;
      e_h = (st == 5 || st == 6) ? m_alh : m_secs / 3600;
      e_m = (st == 5 || st == 6) ? m_alm : (m_secs / 60) % 60;
      e_s = m_secs % 60;
      w = key_run ? 1 : key_mode ? 2 : key_inc ? 3 : key_fast ? 4 : 0;
`ifdef DIGITAL_CLOCK_ALARM_EN
      if (key_run || key_mode || key_inc || key_fast) begin
        e_hit = 0; hit_ticks = 0;
      end else if (old_tick && st == 0 && m_secs == (m_alh * 60 + m_alm) * 60) begin
        e_hit = 1; hit_ticks = 0;
      end else if (e_hit && old_tick) begin
        hit_ticks++;
        if (hit_ticks == 60) e_hit = 0;
      end
`endif
      e_tick = 0;
      if (st == 0 && w != 1 && w != 4) begin
        since++;
        if (since == (fast ? 10 : 100)) begin
          since = 0;
          m_secs = (m_secs + 1) % 86400;
          e_tick = 1;
        end
      end else since = 0;
      if (st >= 2) begin
        set_cyc++;
        if (set_cyc % 25 == 0) e_blink = !e_blink;
      end else begin
        set_cyc = 0; e_blink = 0;
      end
      hh = m_secs / 3600; mm = (m_secs / 60) % 60; ss = m_secs % 60;
      case (w)
        1: st = (st == 0) ? 1 : 0;
        2: if (st != 0) begin
          if (st <= 3) st = st + 1;
`ifdef DIGITAL_CLOCK_ALARM_EN
          else if (st == 4 || st == 5) st = st + 1;
`endif
          else st = 1;
        end
        3: case (st)
          2: m_secs = ((hh + 1) % 24) * 3600 + mm * 60 + ss;
          3: m_secs = hh * 3600 + ((mm + 1) % 60) * 60 + ss;
          4: m_secs = hh * 3600 + mm * 60 + (ss + 1) % 60;
          5: m_alh = (m_alh + 1) % 24;
          6: m_alm = (m_alm + 1) % 60;
          default: ;
        endcase
        4: fast = !fast;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("m_hour", d0_hour, bcd(e_h));
      chk("m_min", d0_min, bcd(e_m));
      chk("m_sec", d0_sec, bcd(e_s));
      chk("m_pm24", d0_pm, 0);
      chk("m_state", d0_state, st);
      chk("m_tick", d0_tick, e_tick);
      chk("m_blink", d0_blink, e_blink);
      chk("m_alarm", d0_hit, e_hit);
      chk("m_hour12", d1_hour, bcd((e_h % 12 == 0) ? 12 : e_h % 12));
      chk("m_pm12", d1_pm, (e_h >= 12) ? 1 : 0);
    end
  end

  task automatic pulse(input bit r, input bit m, input bit i, input bit f);
    @(posedge clk); #1;
    key_run = r; key_mode = m; key_inc = i; key_fast = f;
    @(posedge clk); #1;
    key_run = 0; key_mode = 0; key_inc = 0; key_fast = 0;
  endtask

  task automatic pulses(input bit m, input bit i, input int n);
    for (int k = 0; k < n; k++) pulse(0, m, i, 0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  // Counts rising edges until tick is observed high
  task automatic wait_tick(input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!d0_tick && n < 400);
    if (!d0_tick) chk({nm, "_timeout"}, 0, 1);
  endtask

  int n;
  bit b;

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hour", d0_hour, 8'h00);
    chk("rst_min", d0_min, 8'h00);
    chk("rst_sec", d0_sec, 8'h00);
    chk("rst_state", d0_state, 0);
    chk("rst_tick", d0_tick, 0);
    chk("rst_blink", d0_blink, 0);
    chk("rst_pm", d1_pm, 0);
    chk("rst_alarm", d0_hit, 0);
    @(posedge clk); #1 rst_n = 1; chk_on = 1;

    // first tick exactly CLK_HZ edges after release
    wait_tick("first", n);
    chk("first_tick_latency", n, 100);
    @(negedge clk);
    chk("sec_after_first_tick", d0_sec, 8'h01);

    // 30 hour increments wrap modulo 24 to 06
    do_reset();
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulses(0, 1, 30);
    settle();
    chk("seth_hour", d0_hour, 8'h06);
    chk("seth_min", d0_min, 8'h00);
    chk("seth_sec", d0_sec, 8'h00);
    chk("seth_state", d0_state, 2);
    b = d0_blink; n = 0;
    while (d0_blink == b && n < 60) begin @(posedge clk); n++; @(negedge clk); end
    b = d0_blink; n = 0;
    while (d0_blink == b && n < 60) begin @(posedge clk); n++; @(negedge clk); end
    chk("blink_period", n, 25);

    // key_run beats key_inc in the same cycle
    pulse(1, 0, 1, 0);
    settle();
    chk("run_inc_seth_state", d0_state, 0);
    chk("run_inc_seth_hour", d0_hour, 8'h06);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 1, 0);
    settle();
    chk("run_inc_pause_state", d0_state, 0);
    chk("run_inc_pause_hour", d0_hour, 8'h06);

    // preload 23:59:59 and roll over in one update
    do_reset();
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0); pulses(0, 1, 23);
    pulse(0, 1, 0, 0); pulses(0, 1, 59);
    pulse(0, 1, 0, 0); pulses(0, 1, 59);
    pulse(1, 0, 0, 0);
    settle();
    chk("preload_hour", d0_hour, 8'h23);
    chk("preload_min", d0_min, 8'h59);
    chk("preload_sec", d0_sec, 8'h59);
    wait_tick("rollover", n);
    @(negedge clk);
    chk("rollover_hms", {d0_hour, d0_min, d0_sec}, 24'h000000);

    // fast mode tick spacing
    pulse(0, 0, 0, 1);
    wait_tick("fast_a", n);
    wait_tick("fast_b", n);
    chk("fast_period", n, 10);
    pulse(0, 0, 0, 1);
    wait_tick("slow_a", n);
    wait_tick("slow_b", n);
    chk("slow_period", n, 100);

    // 12 h display of hour 13, then reset mid-SET discards the pending increment
    do_reset();
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulses(0, 1, 13);
    settle();
    chk("h12_hour", d1_hour, 8'h01);
    chk("h12_pm", d1_pm, 1);
    chk("h24_hour", d0_hour, 8'h13);
    @(posedge clk); #1 key_inc = 1; rst_n = 0;
    @(negedge clk);
    chk("midset_rst_hour", d0_hour, 8'h00);
    chk("midset_rst_state", d0_state, 0);
    @(posedge clk); #1 key_inc = 0; rst_n = 1;

    pulse(1, 0, 0, 0);
    pulses(1, 0, 4);
    settle();
`ifdef DIGITAL_CLOCK_ALARM_EN
    chk("mode_seq_after_sets", d0_state, 5);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    settle();
    chk("alarm_disp_min", d0_min, 8'h01);
    chk("alarm_disp_hour", d0_hour, 8'h00);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n = 0;
    while (!d0_hit && n < 1500) begin @(posedge clk); n++; @(negedge clk); end
    chk("alarm_rise", d0_hit, 1);
    chk("alarm_rise_time", {d0_hour, d0_min, d0_sec}, 24'h000100);
    pulse(0, 0, 0, 1);
    settle();
    chk("alarm_clear_key", d0_hit, 0);
`else
    chk("mode_seq_after_sets", d0_state, 1);
    chk("alarm_tied_low", d0_hit, 0);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/digital_clock_ctrl.md
DIGITAL_CLOCK_CTRL -- requirements
Module: digital_clock_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter FAST_DIV, default 1000, tick-rate multiplier in fast mode.
REQ-003 SHALL have parameter H12, default 0, hour display mode: 0 = 24 h, 1 = 12 h with pm flag.
REQ-004 SHALL have port clk, input, 1, system clock; rising-edge only.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port key_run, input, 1, one-cycle debounced pulse; run/pause toggle.
REQ-007 SHALL have port key_mode, input, 1, one-cycle pulse; step the set field.
REQ-008 SHALL have port key_inc, input, 1, one-cycle pulse; increment the selected field.
REQ-009 SHALL have port key_fast, input, 1, one-cycle pulse; toggle fast mode.
REQ-010 SHALL have ports hour_bcd, min_bcd, sec_bcd, output, 8 each, two BCD digits as {tens, units}.
REQ-011 SHALL have port pm, output, 1, afternoon flag; 0 when H12 = 0.
REQ-012 SHALL have ports state_o, output, 3, FSM state code; blink, output, 1, 2 Hz set-mode flasher; tick, output, 1, one-cycle time-advance pulse.
REQ-013 SHALL have port alarm_hit, output, 1, alarm match flag.

Function
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 in normal mode and 0..CLK_HZ/FAST_DIV-1 in fast mode. It SHALL pulse tick for one cycle at terminal count, then return to 0.
REQ-015 FSM states: RUN=0, PAUSE=1, SET_H=2, SET_M=3, SET_S=4 (SET_AH=5, SET_AM=6 per REQ-026).
REQ-016 Prescaler and time advance SHALL operate only in RUN. In all other states the prescaler holds at 0 and tick stays 0.
REQ-017 On tick, sec SHALL advance, with carry sec 59 -> 00 into min and min 59 -> 00 into hour. Hour wraps 23 -> 00. 23:59:59 + tick SHALL give 00:00:00 in the same cycle.
REQ-018 Time SHALL be held internally as BCD, hour 00..23. Outputs SHALL be registered and update the cycle after the change.
REQ-019 key_run SHALL act as follows:
- RUN -> PAUSE.
- Any other state -> RUN.
- Entering RUN SHALL clear the prescaler.
REQ-020 key_mode SHALL step PAUSE -> SET_H -> SET_M -> SET_S -> PAUSE. key_mode SHALL be ignored in RUN.
REQ-021 key_inc in a SET state SHALL increment only the selected field, with no carry. Wraps: hour 23 -> 00, min/sec 59 -> 00. key_inc SHALL be ignored in RUN and PAUSE.
REQ-022 key_fast SHALL toggle fast mode in any state. A toggle SHALL clear the prescaler.
REQ-023 Simultaneous keys: only the highest-priority key SHALL act; priority is key_run > key_mode > key_inc > key_fast. Others in the same cycle SHALL be discarded.
REQ-024 blink SHALL toggle every CLK_HZ/4 cycles in SET states and SHALL be 0 in RUN and PAUSE.
REQ-025 With H12 = 1:
- Internal hour 0 -> display 12, pm = 0.
- Internal hours 1..11 -> display 1..11, pm = 0.
- Internal hour 12 -> display 12, pm = 1.
- Internal hours 13..23 -> display 1..11, pm = 1.

Configuration
REQ-026 With macro DIGITAL_CLOCK_ALARM_EN defined:
- key_mode sequence SHALL become PAUSE -> SET_H -> SET_M -> SET_S -> SET_AH -> SET_AM -> PAUSE.
- key_inc SHALL set the alarm hour/min with the REQ-021 wraps; alarm resets to 00:00.
- While SET_AH/SET_AM is selected, hour_bcd/min_bcd SHALL show the alarm value.
- In RUN, alarm_hit SHALL be 1 from the cycle after the clock reaches alarm HH:MM:00 until any key pulse or 60 s elapse.
REQ-027 Without DIGITAL_CLOCK_ALARM_EN, no alarm registers SHALL exist, states 5 and 6 SHALL be unreachable, and alarm_hit SHALL be tied to 0.

Reset
REQ-028 On rst_n low, asynchronously:
- time = 00:00:00, state = RUN, fast mode off.
- prescaler = 0, blink = 0, tick = 0, pm = 0, alarm_hit = 0.
REQ-029 Reset asserted mid-SET or mid-carry SHALL discard all pending updates. First tick SHALL occur CLK_HZ cycles after rst_n deasserts.

Verification (bench uses CLK_HZ = 100, FAST_DIV = 10)
REQ-030 Reset release then 100 cycles -> tick pulses once; sec_bcd = 8'h01.
REQ-031 Preload 23:59:59 via SET states, key_run, 100 cycles -> 00:00:00 in a single update.
REQ-032 key_run, key_mode, 30 x key_inc -> SET_H shows hour_bcd = 8'h06; min/sec unchanged; blink toggles every 25 cycles.
REQ-033 key_fast in RUN -> tick period becomes 10 cycles; key_fast again -> 100 cycles.
REQ-034 key_run and key_inc in the same cycle in PAUSE -> state RUN; no field changes.
REQ-035 H12 = 1, hour set to 8'h13 -> hour_bcd = 8'h01, pm = 1. With DIGITAL_CLOCK_ALARM_EN, alarm 00:01 in RUN -> alarm_hit rises at 00:01:00 and clears on key_fast.
